adc_chan_deser_mc: RTL and testbench
====================================

Name: adc_chan_deser_mc

Overview:
Parametrised multi-channel deserializer for DDR serial ADC links. It captures N_CHAN serial lines on both edges of ADC_clock and frames them with ADC_word_sync_n, which is edge-detected synchronously rather than used as a clock. Optional chopper demodulation negates each word with saturation. It also checks frame period and counts frames. It sits between the ADC front-end pins and the acquisition/interlock processing chain.

Parameters:
N_CHAN, 8, number of serial ADC lines sharing clock and word sync
DATA_WIDTH, 18, bits per sample, two's complement; must be even when DDR=1
DDR, 1, 1 = sample on both edges (W/2 bits per edge), 0 = posedge only
CHOP_EN, 1, 1 = apply chop_phase negation, 0 = pass raw
FRAME_LEN, 100, expected ADC_clock posedges between consecutive sync falling edges

Ports:
ADC_clock  in  1  ADC bit clock; sole clock, both edges used when DDR=1
ADC_reset  in  1  asynchronous, active-high reset
enable  in  1  0 = ignore sync edges, suppress data_valid, restart frame check
ADC_word_sync_n  in  1  word sync, active-low, synchronous to ADC_clock
ADC_serial_data  in  N_CHAN  serial data, bit i = channel i
chop_phase  in  1  chopper phase; 0 = negate sample (when CHOP_EN=1)
err_clear  in  1  one-cycle pulse, clears frame_err
channel_data  out  N_CHAN*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
data_valid  out  1  one-cycle pulse, channel_data updated
frame_err  out  1  sticky frame-period mismatch flag
frame_count  out  16  accepted frames, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, any time): channel_data=0, data_valid=0, frame_err=0, frame_count=0. Shift registers, sync register, period counter and warm-up counter are cleared. Nothing is flushed; an in-flight frame is lost.
- Sampling: E = DDR ? DATA_WIDTH/2 : DATA_WIDTH. Per channel, pos_sr[E-1:0] shifts in on posedge; neg_sr[E-1:0] shifts in on negedge (DDR=1 only). Negedge logic is limited to the neg_sr shift.
- Strobe: sync_d <= ADC_word_sync_n on posedge. strobe = sync_d & ~ADC_word_sync_n & enable.
- Capture at the strobe posedge uses register contents before that edge's shift.
  - DDR=1: raw = {pos[E-1],neg[E-1],...,pos[0],neg[0]}, MSB oldest.
  - DDR=0: raw = pos_sr.
  - chop_phase is latched at the same edge.
- Warm-up: a strobe is discarded (no capture, no valid, no count) until E posedges have elapsed since reset deassertion.
- Stage 2 (next posedge):
  - channel_data <= (CHOP_EN && latched chop_phase==0) ? sat(-raw) : raw.
  - sat maps -2^(W-1) to 2^(W-1)-1; all other values are exact negation.
  - data_valid=1 for exactly this cycle.
  - frame_count increments on this same cycle.
  - Latency: data_valid is high at strobe posedge +1.
- Frame check:
  - The period counter counts posedges since the last accepted strobe and saturates at 0xFFFF.
  - On an accepted strobe after the first one, counter != FRAME_LEN sets frame_err.
  - The first accepted strobe after reset, or after enable rises, is not checked.
  - enable=0 holds the counter cleared.
  - err_clear clears frame_err; if a mismatch occurs in the same cycle, the set wins.
- Sync held low: no repeated strobes. Sync glitch high-low: a new strobe occurs and is period-checked normally.
- channel_data holds its last value between valids and while enable=0.

Test Plan:
1. DDR=1, W=18, ch0 streams 0x2AAAA MSB-first across both edges, chop_phase=1 -> data_valid 1 cycle after strobe, ch0=0x2AAAA, ch1 (0x15555 streamed)=0x15555, frame_count=1.
2. chop_phase=0, raw 0x00001 -> 0x3FFFF. Raw 0x20000 -> 0x1FFFF (saturated). With CHOP_EN=0, raw 0x20000 -> 0x20000.
3. Sync falls every 100 posedges for 5 frames -> frame_err=0, frame_count=5. Then one 99-cycle period -> frame_err=1 at that strobe, held. err_clear pulse -> 0. Mismatch coincident with err_clear -> frame_err=1.
4. Strobe 3 posedges after reset release (E=9) -> no data_valid, frame_count=0. Next strobe at +100 -> captured, not period-checked, frame_err=0.
5. ADC_reset asserted mid-frame 40 posedges after a strobe -> all outputs 0 immediately (async). Strobe 100 cycles after release -> valid, count=1, no error.
6. enable=0 across 3 sync edges -> no valid, count unchanged, channel_data held. enable=1 then strobes 100 apart -> first unchecked, second checked, no error.

Source files
------------

// File: rtl/adc_chan_deser_mc.sv
// rtl/adc_chan_deser_mc.sv - multi-channel DDR serial ADC deserializer with chop demod and frame check
module adc_chan_deser_mc #(
  parameter int N_CHAN     = 8,
  parameter int DATA_WIDTH = 18,
  parameter int DDR        = 1,
  parameter int CHOP_EN    = 1,
  parameter int FRAME_LEN  = 100
) (
  input  logic                         ADC_clock,
  input  logic                         ADC_reset,
  input  logic                         enable,
  input  logic                         ADC_word_sync_n,
  input  logic [N_CHAN-1:0]            ADC_serial_data,
  input  logic                         chop_phase,
  input  logic                         err_clear,
  output logic [N_CHAN*DATA_WIDTH-1:0] channel_data,
  output logic                         data_valid,
  output logic                         frame_err,
  output logic [15:0]                  frame_count
);

  // Bits captured per edge type in one word
  localparam int E  = (DDR != 0) ? DATA_WIDTH / 2 : DATA_WIDTH;
  localparam int WW = $clog2(E + 1);
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SMAX = ~SMIN;

  logic          r_sync_d;
  logic          r_chop;
  logic          r_cap;
  logic          r_armed;
  logic [WW-1:0] r_warm;
  logic [15:0]   r_period;
  logic          w_strobe;
  logic          w_warm_ok;
  logic          w_accept;
  logic          w_mismatch;

  // Sync falling edge seen while enabled; discarded until the shift registers have filled
  assign w_strobe   = r_sync_d & ~ADC_word_sync_n & enable;
  assign w_warm_ok  = (r_warm == WW'(E));
  assign w_accept   = w_strobe & w_warm_ok;
  assign w_mismatch = w_accept & r_armed & (r_period != 16'(FRAME_LEN));

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    logic [E-1:0]          r_pos_sr;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [DATA_WIDTH-1:0] r_raw;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_neg;

    // Posedge sample shift, newest bit in LSB
    always_ff @(posedge ADC_clock or posedge ADC_reset) begin
      if (ADC_reset) r_pos_sr <= '0;
      else           r_pos_sr <= {r_pos_sr[E-2:0], ADC_serial_data[c]};
    end

    if (DDR != 0) begin : g_ddr
      logic [E-1:0] r_neg_sr;

      // Negedge sample shift; the only logic clocked on the falling edge
      always_ff @(negedge ADC_clock or posedge ADC_reset) begin
        if (ADC_reset) r_neg_sr <= '0;
        else           r_neg_sr <= {r_neg_sr[E-2:0], ADC_serial_data[c]};
      end

      // Interleave so each posedge bit precedes the negedge bit that followed it
      always_comb begin
        w_raw = '0;
        for (int b = 0; b < E; b++) begin
          w_raw[2*b+1] = r_pos_sr[b];
          w_raw[2*b]   = r_neg_sr[b];
        end
      end
    end else begin : g_sdr
      assign w_raw = r_pos_sr;
    end

    // Negation saturates the single value that has no positive counterpart
    assign w_neg = (r_raw == SMIN) ? SMAX : (~r_raw + 1'b1);

    // Capture raw word at the strobe, demodulate into the output one edge later
    always_ff @(posedge ADC_clock or posedge ADC_reset) begin
      if (ADC_reset) begin
        r_raw  <= '0;
        r_data <= '0;
      end else begin
        if (w_accept) r_raw <= w_raw;
        if (r_cap)    r_data <= ((CHOP_EN != 0) && !r_chop) ? w_neg : r_raw;
      end
    end

    assign channel_data[c*DATA_WIDTH +: DATA_WIDTH] = r_data;
  end

  // Sync edge detect, warm-up, valid pulse, frame counting and period check
  always_ff @(posedge ADC_clock or posedge ADC_reset) begin
    if (ADC_reset) begin
      r_sync_d    <= 1'b0;
      r_warm      <= '0;
      r_cap       <= 1'b0;
      r_chop      <= 1'b0;
      r_armed     <= 1'b0;
      r_period    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      r_sync_d   <= ADC_word_sync_n;
      r_cap      <= w_accept;
      data_valid <= r_cap;
      if (!w_warm_ok) r_warm <= r_warm + 1'b1;
      if (w_accept)   r_chop <= chop_phase;
      if (r_cap)      frame_count <= frame_count + 16'd1;
      if (!enable) begin
        r_period <= '0;
        r_armed  <= 1'b0;
      end else if (w_accept) begin
        r_period <= 16'd1;
        r_armed  <= 1'b1;
      end else if (r_period != 16'hFFFF) begin
        r_period <= r_period + 16'd1;
      end
      if (w_mismatch)     frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_chan_deser_mc.sv
// tb/tb_adc_chan_deser_mc.sv - directed self-checking bench for adc_chan_deser_mc
module tb_adc_chan_deser_mc;

  localparam int N = 8;
  localparam int W = 18;

  logic             ADC_clock;
  logic             ADC_reset;
  logic             enable;
  logic             ADC_word_sync_n;
  logic [N-1:0]     ADC_serial_data;
  logic             chop_phase;
  logic             err_clear;
  logic [N*W-1:0]   channel_data;
  logic             data_valid;
  logic             frame_err;
  logic [15:0]      frame_count;
  logic [N*W-1:0]   nc_data;
  logic             nc_valid;
  logic             nc_err;
  logic [15:0]      nc_count;

  int n_checks = 0;
  int n_fail   = 0;

  adc_chan_deser_mc dut (
    .ADC_clock(ADC_clock), .ADC_reset(ADC_reset), .enable(enable),
    .ADC_word_sync_n(ADC_word_sync_n), .ADC_serial_data(ADC_serial_data),
    .chop_phase(chop_phase), .err_clear(err_clear), .channel_data(channel_data),
    .data_valid(data_valid), .frame_err(frame_err), .frame_count(frame_count)
  );

  adc_chan_deser_mc #(.CHOP_EN(0)) dut_nc (
    .ADC_clock(ADC_clock), .ADC_reset(ADC_reset), .enable(enable),
    .ADC_word_sync_n(ADC_word_sync_n), .ADC_serial_data(ADC_serial_data),
    .chop_phase(chop_phase), .err_clear(err_clear), .channel_data(nc_data),
    .data_valid(nc_valid), .frame_err(nc_err), .frame_count(nc_count)
  );

  initial begin
    ADC_clock = 1'b0;
    forever #5 ADC_clock = ~ADC_clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] chan(input logic [N*W-1:0] bus, input int i);
    return bus[i*W +: W];
  endfunction

  // One bit period: pb sampled at the posedge, nb at the following negedge
  task automatic tick(input logic [N-1:0] pb, input logic [N-1:0] nb, input logic s);
    ADC_serial_data = pb;
    ADC_word_sync_n = s;
    @(posedge ADC_clock); #1;
    ADC_serial_data = nb;
    @(negedge ADC_clock); #1;
  endtask

  // n posedges ending in a strobe; the last 9 before it carry w0/w1 MSB first
  task automatic strobe_after(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic chop, input logic clr);
    for (int i = 0; i < n - 10; i++) tick('0, '0, 1'b1);
    chop_phase = chop;
    for (int j = 0; j < 9; j++)
      tick({6'b0, w1[17-2*j], w0[17-2*j]}, {6'b0, w1[16-2*j], w0[16-2*j]}, 1'b1);
    err_clear = clr;
    tick('0, '0, 1'b0);
    err_clear = 1'b0;
  endtask

  task automatic tick_chk();
    tick('0, '0, 1'b0);
  endtask

  task automatic chk_frame(input string tag, input logic v, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input int ecnt, input logic eerr);
    check_eq({tag, "_valid"}, 32'(data_valid), 32'(v));
    check_eq({tag, "_ch0"}, 32'(chan(channel_data, 0)), 32'(e0));
    check_eq({tag, "_ch1"}, 32'(chan(channel_data, 1)), 32'(e1));
    check_eq({tag, "_cnt"}, 32'(frame_count), 32'(ecnt));
    check_eq({tag, "_err"}, 32'(frame_err), 32'(eerr));
  endtask

  initial begin
    ADC_reset = 1'b0;
    enable = 1'b1;
    ADC_word_sync_n = 1'b1;
    ADC_serial_data = '0;
    chop_phase = 1'b1;
    err_clear = 1'b0;
    #1 ADC_reset = 1'b1;
    @(negedge ADC_clock); #1;
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_cnt", 32'(frame_count), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);
    check_eq("rst_data_lo", channel_data[31:0], 32'd0);
    ADC_reset = 1'b0;

    // Warm-up: strobe at posedge 3 after release is discarded
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b0);
    tick_chk();
    check_eq("warm_valid", 32'(data_valid), 32'd0);
    check_eq("warm_cnt", 32'(frame_count), 32'd0);

    // First accepted frame, unchecked; DDR bit ordering
    strobe_after(99, 18'h2AAAA, 18'h15555, 1'b1, 1'b0);
    tick_chk();
    chk_frame("f1", 1'b1, 18'h2AAAA, 18'h15555, 1, 1'b0);
    check_eq("f1_ch2", 32'(chan(channel_data, 2)), 32'd0);

    // Chop negation and saturation
    strobe_after(99, 18'h00001, 18'h20000, 1'b0, 1'b0);
    tick_chk();
    chk_frame("f2", 1'b1, 18'h3FFFF, 18'h1FFFF, 2, 1'b0);
    check_eq("f2_nc_ch0", 32'(chan(nc_data, 0)), 32'h00001);
    check_eq("f2_nc_ch1", 32'(chan(nc_data, 1)), 32'h20000);
    check_eq("f2_nc_valid", 32'(nc_valid), 32'd1);

    strobe_after(99, 18'h1FFFF, 18'h00000, 1'b0, 1'b0);
    tick_chk();
    chk_frame("f3", 1'b1, 18'h20001, 18'h00000, 3, 1'b0);

    strobe_after(99, 18'h20000, 18'h3FFFF, 1'b1, 1'b0);
    tick_chk();
    chk_frame("f4", 1'b1, 18'h20000, 18'h3FFFF, 4, 1'b0);

    strobe_after(99, 18'h3FFFF, 18'h0AAAA, 1'b0, 1'b0);
    tick_chk();
    chk_frame("f5", 1'b1, 18'h00001, 18'h35556, 5, 1'b0);

    // Short period sets the sticky error
    strobe_after(98, 18'h12345, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("f6", 1'b1, 18'h12345, 18'h00000, 6, 1'b1);

    strobe_after(99, 18'h00F00, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("f7", 1'b1, 18'h00F00, 18'h00000, 7, 1'b1);

    // err_clear pulse during a non-strobe cycle
    err_clear = 1'b1;
    tick('0, '0, 1'b1);
    err_clear = 1'b0;
    check_eq("clr_err", 32'(frame_err), 32'd0);
    check_eq("clr_valid", 32'(data_valid), 32'd0);
    strobe_after(98, 18'h00055, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("f8", 1'b1, 18'h00055, 18'h00000, 8, 1'b0);

    // Mismatch coincident with err_clear: set wins
    strobe_after(100, 18'h000AA, 18'h00000, 1'b1, 1'b1);
    tick_chk();
    chk_frame("f9", 1'b1, 18'h000AA, 18'h00000, 9, 1'b1);
    check_eq("f9_nc_err", 32'(nc_err), 32'd1);

    // Async reset 40 posedges after the strobe
    for (int i = 0; i < 39; i++) tick('0, '0, 1'b1);
    ADC_reset = 1'b1;
    #1;
    chk_frame("arst", 1'b0, 18'h00000, 18'h00000, 0, 1'b0);
    check_eq("arst_nc_cnt", 32'(nc_count), 32'd0);
    ADC_reset = 1'b0;
    strobe_after(100, 18'h0F0F0, 18'h33333, 1'b1, 1'b0);
    tick_chk();
    chk_frame("post_rst", 1'b1, 18'h0F0F0, 18'h33333, 1, 1'b0);

    // Disabled: sync edges ignored, output held
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe_after(99, 18'h11111, 18'h22222, 1'b1, 1'b0);
      tick_chk();
      check_eq("dis_valid", 32'(data_valid), 32'd0);
    end
    chk_frame("dis", 1'b0, 18'h0F0F0, 18'h33333, 1, 1'b0);

    // Re-enable: first strobe unchecked, later ones checked
    enable = 1'b1;
    strobe_after(37, 18'h00ABC, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("en1", 1'b1, 18'h00ABC, 18'h00000, 2, 1'b0);
    strobe_after(99, 18'h1C3C3, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("en2", 1'b1, 18'h1C3C3, 18'h00000, 3, 1'b0);
    strobe_after(49, 18'h00007, 18'h00000, 1'b1, 1'b0);
    tick_chk();
    chk_frame("en3", 1'b1, 18'h00007, 18'h00000, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
